addsub_pipe: RTL and testbench

- Parametrised, pipelined add/subtract unit; next generation of the single-cycle 32-bit adder used in the MIPS datapath.
- Splits the operand into STAGES equal slices and ripples the carry one slice per clock, so wide adds close timing in the multi-cycle and pipelined implementations.
- Adds a subtract mode, carry/overflow/zero flags and a valid/ready handshake with backpressure.
- Sits between ALU operand muxes and the result writeback/branch-compare logic.

---
 rtl/add_pkg.sv | 11 +
 rtl/add_slice.sv | 48 ++++
 rtl/addsub_pipe.sv | 98 +++++++++
 tb/tb_addsub_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package add_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_slice.sv
// One registered pipeline slice: adds bits [IDX*SW +: SW] and forwards operands, partial result and carry.
module add_slice #(
  parameter int WIDTH = 32,
  parameter int SW    = 16,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] r_in,
  input  logic             carry_in,
  output logic             valid,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] r_q,
  output logic             carry_q
);

  logic [SW:0]      sum;
  logic [WIDTH-1:0] r_next;

  assign sum = {1'b0, a_in[IDX*SW +: SW]} + {1'b0, b_in[IDX*SW +: SW]} + {{SW{1'b0}}, carry_in};

  always_comb begin
    r_next = r_in;
    r_next[IDX*SW +: SW] = sum[SW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
    end else if (load) begin
      valid   <= valid_in;
      a_q     <= a_in;
      b_q     <= b_in;
      r_q     <= r_next;
      carry_q <= sum[SW];
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: carry ripples one slice per clock, valid/ready handshake with backpressure.
module addsub_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SW   = slice_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] c_s;
  logic [WIDTH-1:0]  a_s [STAGES];
  logic [WIDTH-1:0]  b_s [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];

  // A stage stalls only if it and every stage downstream hold a beat while the consumer refuses.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      logic stall;
      stall = !out_ready;
      for (int j = k; j < STAGES; j++) begin
        stall = stall && v[j];
      end
      adv[k] = !stall;
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] r_i;
    logic             c_i;
    logic             v_i;

    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1, so the inversion and carry-in happen once at entry.
      assign a_i = a;
      assign b_i = (op == OP_SUB) ? ~b : b;
      assign r_i = '0;
      assign c_i = (op == OP_SUB);
      assign v_i = in_valid;
    end else begin : g_next
      assign a_i = a_s[k-1];
      assign b_i = b_s[k-1];
      assign r_i = r_s[k-1];
      assign c_i = c_s[k-1];
      assign v_i = v[k-1];
    end

    add_slice #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .IDX   (k)
    ) u_slice (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (adv[k]),
      .valid_in (v_i),
      .a_in     (a_i),
      .b_in     (b_i),
      .r_in     (r_i),
      .carry_in (c_i),
      .valid    (v[k]),
      .a_q      (a_s[k]),
      .b_q      (b_s[k]),
      .r_q      (r_s[k]),
      .carry_q  (c_s[k])
    );
  end

  assign out_valid = v[LAST];
  assign result    = r_s[LAST];
  assign carry_out = c_s[LAST];
  assign overflow  = (a_s[LAST][WIDTH-1] == b_s[LAST][WIDTH-1]) &&
                     (r_s[LAST][WIDTH-1] != a_s[LAST][WIDTH-1]);
  assign zero      = ~|r_s[LAST];

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed checks on the default 32-bit/2-stage unit plus a scoreboarded sweep of a 64-bit/4-stage unit.
module tb_addsub_pipe;
  import add_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, op, out_valid, out_ready, carry_out, overflow, zero;
  logic [31:0] a, b, result;

  logic        in_valid64, in_ready64, op64, out_valid64, out_ready64;
  logic        carry_out64, overflow64, zero64;
  logic [63:0] a64, b64, result64;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] r;
    logic        c;
    logic        ov;
    logic        z;
  } exp_t;

  addsub_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  addsub_pipe #(.WIDTH(64), .STAGES(4)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .op(op64), .out_valid(out_valid64), .out_ready(out_ready64),
    .result(result64), .carry_out(carry_out64), .overflow(overflow64), .zero(zero64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offers one beat, then checks it two edges later on the 32-bit unit.
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                               input logic [31:0] er, input logic ec, input logic eov, input logic ez);
    a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b1;
    #1 checkOutput("vec_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = ~vop;
    @(posedge clk); #1;
    checkOutput("vec_out_valid", 64'(out_valid), 64'd1);
    checkOutput("vec_result",    64'(result),    64'(er));
    checkOutput("vec_carry",     64'(carry_out), 64'(ec));
    checkOutput("vec_overflow",  64'(overflow),  64'(eov));
    checkOutput("vec_zero",      64'(zero),      64'(ez));
  endtask

  // Independent reference: plain integer arithmetic and signed range test.
  function automatic exp_t model64(input logic [63:0] x, input logic [63:0] y, input logic o);
    logic [64:0]        s;
    logic signed [64:0] ss;
    exp_t               e;
    if (o == OP_SUB) begin
      s    = {1'b0, x} - {1'b0, y};
      ss   = $signed({x[63], x}) - $signed({y[63], y});
      e.c  = (x >= y);
    end else begin
      s    = {1'b0, x} + {1'b0, y};
      ss   = $signed({x[63], x}) + $signed({y[63], y});
      e.c  = s[64];
    end
    e.r  = s[63:0];
    e.ov = (ss[64] != ss[63]);
    e.z  = (e.r == 64'd0);
    return e;
  endfunction

  initial begin
    int   sent, recv, cyc, lat;
    logic acc, take;
    exp_t sb[$];
    exp_t e;

    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = OP_ADD; out_ready = 1'b0;
    in_valid64 = 1'b0; a64 = '0; b64 = '0; op64 = OP_ADD; out_ready64 = 1'b0;
    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result",    64'(result),    64'd0);
    checkOutput("rst_carry",     64'(carry_out), 64'd0);
    checkOutput("rst_overflow",  64'(overflow),  64'd0);
    checkOutput("rst_zero",      64'(zero),      64'd1);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(32'h0000_0005, 32'h0000_0003, OP_ADD, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, OP_ADD, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0005, 32'h0000_0005, OP_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0000_0003, 32'h0000_0005, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Backpressure: beat i is (100+i)+i, so results are 100+2i.
    sent = 0; recv = 0; out_ready = 1'b0; op = OP_ADD;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; a = 32'(100 + sent); b = 32'(sent);
      #1 acc = in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    checkOutput("bp_accepted", 64'(sent), 64'd2);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_hold_result", 64'(result), 64'd100);

    out_ready = 1'b1; cyc = 0;
    while (recv < 6 && cyc < 20) begin
      if (sent < 6) begin
        in_valid = 1'b1; a = 32'(100 + sent); b = 32'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (take) begin
        checkOutput("bp_result", 64'(result), 64'(100 + 2 * recv));
        recv++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("bp_received", 64'(recv), 64'd6);
    checkOutput("bp_drain_cycles", 64'(cyc), 64'd6);
    @(posedge clk); #1;
    checkOutput("bp_empty", 64'(out_valid), 64'd0);

    // Reset with two beats in flight.
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 32'd7; b = 32'd1;
    @(posedge clk); #1;
    a = 32'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("rst_pre_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid",  64'(out_valid), 64'd0);
    checkOutput("rst_mid_result", 64'(result),    64'd0);
    checkOutput("rst_mid_zero",   64'(zero),      64'd1);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h0000_0011, 32'h0000_0022, OP_ADD, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("rst_alone", 64'(out_valid), 64'd0);

    // 64-bit unit: unstalled latency with carry crossing a slice boundary.
    in_valid64 = 1'b1; out_ready64 = 1'b1; op64 = OP_ADD;
    a64 = 64'h0000_0001_FFFF_FFFF; b64 = 64'h0000_0000_0000_0001;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    lat = 1;
    while (!out_valid64 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("w64_latency", 64'(lat), 64'd4);
    checkOutput("w64_result", result64, 64'h0000_0002_0000_0000);
    @(posedge clk); #1;

    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      in_valid64  = (sent < 1000) && ($urandom_range(3) != 0);
      a64         = {$urandom, $urandom};
      b64         = ($urandom_range(7) == 0) ? a64 : {$urandom, $urandom};
      op64        = 1'($urandom_range(1));
      out_ready64 = ($urandom_range(3) != 0);
      #1;
      if (in_valid64 && in_ready64) begin
        sb.push_back(model64(a64, b64, op64));
        sent++;
      end
      if (out_valid64 && out_ready64) begin
        if (sb.size() == 0) begin
          checkOutput("w64_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("w64_result",   result64,            e.r);
          checkOutput("w64_carry",    64'(carry_out64),    64'(e.c));
          checkOutput("w64_overflow", 64'(overflow64),     64'(e.ov));
          checkOutput("w64_zero",     64'(zero64),         64'(e.z));
        end
        recv++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid64 = 1'b0;
    checkOutput("w64_received", 64'(recv), 64'd1000);
    checkOutput("w64_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
